// File: rtl/gpr_wr_if.sv
// Requester-side bus of the register-file write arbiter: stall, per-requester
// request/address/data, and the one-hot grant returned in the same cycle.
interface gpr_wr_if #(
    parameter int NREQ   = 3,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic                     stall;
    logic [NREQ-1:0]          req;
    logic [NREQ*ADDR_W-1:0]   req_addr;
    logic [NREQ*DATA_W-1:0]   req_data;
    logic [NREQ-1:0]          gnt;

    modport master (
        output stall,
        output req,
        output req_addr,
        output req_data,
        input  gnt
    );

    modport slave (
        input  stall,
        input  req,
        input  req_addr,
        input  req_data,
        output gnt
    );
endinterface

// File: rtl/gpr_wr_arbiter.sv
// Round-robin arbiter sharing the single register-file write port between
// NREQ write-back sources; the winner's write is registered one cycle later.
module gpr_wr_arbiter #(
    parameter int  NREQ   = 3,
    parameter int  ADDR_W = 5,
    parameter int  DATA_W = 32,
    localparam int PTR_W  = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              reset,
    gpr_wr_if.slave           bus,
    output logic              WE_,
    output logic [ADDR_W-1:0] WrAddr,
    output logic [DATA_W-1:0] WrData,
    output logic [PTR_W-1:0]  last_gnt
);
    localparam logic [PTR_W:0]   NREQ_L  = (PTR_W+1)'(NREQ);
    localparam logic [PTR_W-1:0] PTR_RST = PTR_W'(NREQ - 1);

    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;

    logic              en_s, found_s, hit_s;
    logic [PTR_W-1:0]  win_s;
    logic [PTR_W:0]    sum_s, idx_s;
    logic [NREQ-1:0]   gnt_s;
    logic [ADDR_W-1:0] win_addr_s;
    logic [DATA_W-1:0] win_data_s;

    // Scan from ptr+1 upward; the sum is one bit wider so a non-power-of-two wrap is explicit.
    always_comb begin
        en_s    = ~reset & ~bus.stall;
        found_s = 1'b0;
        win_s   = ptr_q;
        sum_s   = '0;
        idx_s   = '0;
        hit_s   = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            sum_s   = {1'b0, ptr_q} + k[PTR_W:0];
            idx_s   = (sum_s >= NREQ_L) ? (sum_s - NREQ_L) : sum_s;
            hit_s   = en_s & ~found_s & bus.req[idx_s[PTR_W-1:0]];
            win_s   = hit_s ? idx_s[PTR_W-1:0] : win_s;
            found_s = found_s | hit_s;
        end
    end

    // One-hot grant, winner payload mux and next state of the write stage.
    always_comb begin
        gnt_s      = '0;
        win_addr_s = '0;
        win_data_s = '0;
        for (int i = 0; i < NREQ; i++) begin
            gnt_s[i]   = found_s & (win_s == PTR_W'(i));
            win_addr_s = gnt_s[i] ? bus.req_addr[i*ADDR_W +: ADDR_W] : win_addr_s;
            win_data_s = gnt_s[i] ? bus.req_data[i*DATA_W +: DATA_W] : win_data_s;
        end
        we_d      = ~found_s;
        wr_addr_d = found_s ? win_addr_s : wr_addr_q;
        wr_data_d = found_s ? win_data_s : wr_data_q;
        ptr_d     = found_s ? win_s      : ptr_q;
    end

    // Write-port registers and round-robin pointer; reset drops any pending write.
    always_ff @(posedge clk) begin
        if (reset) begin
            we_q      <= 1'b1;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            ptr_q     <= PTR_RST;
        end else begin
            we_q      <= we_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            ptr_q     <= ptr_d;
        end
    end

    // The pointer always holds the most recent winner, so it doubles as last_gnt.
    assign bus.gnt  = gnt_s;
    assign WE_      = we_q;
    assign WrAddr   = wr_addr_q;
    assign WrData   = wr_data_q;
    assign last_gnt = ptr_q;
endmodule
